// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter and its round-robin grant logic.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int unsigned DM_MEM_BYTES  = 64;
  localparam int unsigned WORD_BYTES    = 8;
  localparam int unsigned WORD_OFS_BITS = 3;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last winner remembered on accept.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  // On a tie the requester that did not win last time is preferred.
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11)
      o_grant = (r_last_grant == REQ_LOADER) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_grant <= REQ_LOADER;
    else if (i_accept)
      r_last_grant <= o_grant[1];
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Core/loader arbiter and one-cycle access sequencer for the 64-byte data memory.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_BYTES = DM_MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  output logic              c_rsp_err,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic              l_req_we,
  input  logic [ADDR_W-1:0] l_req_addr,
  input  logic [DATA_W-1:0] l_req_wdata,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_rdata,
  output logic              l_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_t              r_state;
  logic                r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_write_data;
  logic                r_mem_write;
  logic                r_mem_read;
  logic                r_c_rsp_valid;
  logic [DATA_W-1:0]   r_c_rsp_rdata;
  logic                r_c_rsp_err;
  logic                r_l_rsp_valid;
  logic [DATA_W-1:0]   r_l_rsp_rdata;
  logic                r_l_rsp_err;

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_hs;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_legal;

  assign w_req = {l_req_valid, c_req_valid} & {2{r_state == IDLE}};

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_req),
    .i_accept (w_hs),
    .o_grant  (w_grant)
  );

  assign c_req_ready = w_grant[0];
  assign l_req_ready = w_grant[1];
  assign w_hs        = |w_grant;

  assign w_sel_we    = w_grant[1] ? l_req_we    : c_req_we;
  assign w_sel_addr  = w_grant[1] ? l_req_addr  : c_req_addr;
  assign w_sel_wdata = w_grant[1] ? l_req_wdata : c_req_wdata;
  assign w_legal     = (w_sel_addr[WORD_OFS_BITS-1:0] == '0) && (w_sel_addr <= LAST_WORD);

  // Memory-side strobes are loaded at the handshake edge so they are pure flops
  // and drop with the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_id          <= REQ_CORE;
      r_we          <= 1'b0;
      r_mem_addr    <= '0;
      r_write_data  <= '0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_c_rsp_valid <= 1'b0;
      r_c_rsp_rdata <= '0;
      r_c_rsp_err   <= 1'b0;
      r_l_rsp_valid <= 1'b0;
      r_l_rsp_rdata <= '0;
      r_l_rsp_err   <= 1'b0;
    end else begin
      r_mem_addr    <= '0;
      r_write_data  <= '0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_c_rsp_valid <= 1'b0;
      r_c_rsp_rdata <= '0;
      r_c_rsp_err   <= 1'b0;
      r_l_rsp_valid <= 1'b0;
      r_l_rsp_rdata <= '0;
      r_l_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_id <= w_grant[1];
            r_we <= w_sel_we;
            if (w_legal) begin
              r_state      <= ACCESS;
              r_mem_addr   <= w_sel_addr;
              r_write_data <= w_sel_we ? w_sel_wdata : '0;
              r_mem_write  <= w_sel_we;
              r_mem_read   <= !w_sel_we;
            end else begin
              r_state <= RESP;
              if (w_grant[1] == REQ_LOADER) begin
                r_l_rsp_valid <= 1'b1;
                r_l_rsp_err   <= 1'b1;
              end else begin
                r_c_rsp_valid <= 1'b1;
                r_c_rsp_err   <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          r_state <= RESP;
          if (r_id == REQ_LOADER) begin
            r_l_rsp_valid <= 1'b1;
            r_l_rsp_rdata <= r_we ? '0 : read_data;
          end else begin
            r_c_rsp_valid <= 1'b1;
            r_c_rsp_rdata <= r_we ? '0 : read_data;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign write_data  = r_write_data;
  assign mem_write   = r_mem_write;
  assign mem_read    = r_mem_read;
  assign c_rsp_valid = r_c_rsp_valid;
  assign c_rsp_rdata = r_c_rsp_rdata;
  assign c_rsp_err   = r_c_rsp_err;
  assign l_rsp_valid = r_l_rsp_valid;
  assign l_rsp_rdata = r_l_rsp_rdata;
  assign l_rsp_err   = r_l_rsp_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-array memory that writes on negedge.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [63:0] c_req_addr, c_req_wdata;
  logic        c_rsp_valid, c_rsp_err;
  logic [63:0] c_rsp_rdata;
  logic        l_req_valid, l_req_ready, l_req_we;
  logic [63:0] l_req_addr, l_req_wdata;
  logic        l_rsp_valid, l_rsp_err;
  logic [63:0] l_rsp_rdata;
  logic [63:0] mem_addr, write_data, read_data;
  logic        mem_write, mem_read;

  logic [7:0]  mem [0:63];
  int          wr_cnt;
  int          rd_cnt;
  int          n_tests;
  int          n_fail;

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata), .l_rsp_err(l_rsp_err),
    .mem_addr(mem_addr), .write_data(write_data), .mem_write(mem_write),
    .mem_read(mem_read), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preset mem[i]=i, commit stores on negedge, count strobe cycles.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    wr_cnt = 0;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) begin
        wr_cnt++;
        for (int i = 0; i < 8; i++) mem[int'(mem_addr[5:0]) + i] = write_data[8*i +: 8];
      end
      if (mem_read === 1'b1) rd_cnt++;
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < 8; i++)
      if (int'(mem_addr[5:0]) + i < 64) read_data[8*i +: 8] = mem[int'(mem_addr[5:0]) + i];
  end

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem[a + i];
    return w;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_req_valid = 0; c_req_we = 0; c_req_addr = '0; c_req_wdata = '0;
    l_req_valid = 0; l_req_we = 0; l_req_addr = '0; l_req_wdata = '0;
    #3;
    n_tests++;
    if ({c_req_ready, l_req_ready, c_rsp_valid, c_rsp_err, c_rsp_rdata, l_rsp_valid, l_rsp_err,
         l_rsp_rdata, mem_addr, write_data, mem_write, mem_read} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got mem_write=%b mem_read=%b c_rsp_valid=%b l_rsp_valid=%b, expected all 0",
               mem_write, mem_read, c_rsp_valid, l_rsp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_tests++;
    if ({c_req_ready, l_req_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready_idle: got %b expected 00", {c_req_ready, l_req_ready});
    end
  endtask

  task automatic test_round_robin();
    int k;
    c_req_valid = 1; c_req_we = 0; c_req_addr = 64'd0;
    l_req_valid = 1; l_req_we = 0; l_req_addr = 64'd16;
    #1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!(c_req_ready || l_req_ready) && k < 6) begin
        cycle();
        k++;
      end
      n_tests++;
      if (k == 6) begin
        n_fail++;
        $display("FAIL rr_grant_timeout[%0d]: no ready within 6 cycles, expected a grant", i);
      end else if ({c_req_ready, l_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got c/l ready=%b expected %b", i,
                 {c_req_ready, l_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      cycle();
    end
    c_req_valid = 0;
    l_req_valid = 0;
    cycle();
    cycle();
  endtask

  task automatic test_store_load();
    l_req_valid = 1; l_req_we = 1; l_req_addr = 64'd8; l_req_wdata = 64'h1122334455667788;
    #1;
    n_tests++;
    if (l_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_store_ready: got %b expected 1", l_req_ready);
    end
    cycle();
    l_req_valid = 0;
    n_tests++;
    if ({mem_write, mem_read, mem_addr, write_data} !== {1'b1, 1'b0, 64'd8, 64'h1122334455667788}) begin
      n_fail++;
      $display("FAIL ld_store_access: got we=%b rd=%b addr=%h wd=%h expected 1 0 8 1122334455667788",
               mem_write, mem_read, mem_addr, write_data);
    end
    cycle();
    n_tests++;
    if ({l_rsp_valid, l_rsp_err, l_rsp_rdata, c_rsp_valid} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ld_store_rsp: got lv=%b le=%b ld=%h cv=%b expected 1 0 0 0",
               l_rsp_valid, l_rsp_err, l_rsp_rdata, c_rsp_valid);
    end
    cycle();
    c_req_valid = 1; c_req_we = 0; c_req_addr = 64'd8;
    #1;
    cycle();
    c_req_valid = 0;
    n_tests++;
    if ({mem_read, c_rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL core_load_access: got rd=%b cv=%b expected 1 0", mem_read, c_rsp_valid);
    end
    cycle();
    n_tests++;
    if ({c_rsp_valid, c_rsp_err, c_rsp_rdata, l_rsp_valid} !== {1'b1, 1'b0, 64'h1122334455667788, 1'b0}) begin
      n_fail++;
      $display("FAIL core_load_rsp: got cv=%b ce=%b cd=%h lv=%b expected 1 0 1122334455667788 0",
               c_rsp_valid, c_rsp_err, c_rsp_rdata, l_rsp_valid);
    end
    cycle();
    n_tests++;
    if (c_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL core_load_rsp_pulse: got %b expected 0", c_rsp_valid);
    end
  endtask

  task automatic test_misaligned();
    int wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    c_req_valid = 1; c_req_we = 0; c_req_addr = 64'h0C;
    #1;
    cycle();
    c_req_valid = 0;
    n_tests++;
    if ({c_rsp_valid, c_rsp_err, c_rsp_rdata, mem_read, mem_write} !== {1'b1, 1'b1, 64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL misaligned_rsp: got cv=%b ce=%b cd=%h rd=%b wr=%b expected 1 1 0 0 0",
               c_rsp_valid, c_rsp_err, c_rsp_rdata, mem_read, mem_write);
    end
    cycle();
    n_tests++;
    if ({wr_cnt - wr0, rd_cnt - rd0, c_rsp_valid} !== {32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL misaligned_strobes: got wr=%0d rd=%0d cv=%b expected 0 0 0",
               wr_cnt - wr0, rd_cnt - rd0, c_rsp_valid);
    end
  endtask

  task automatic test_range();
    logic [63:0] addrs [3];
    logic        errs  [3];
    int wr0, rd0;
    addrs[0] = 64'd56;          errs[0] = 1'b0;
    addrs[1] = 64'd64;          errs[1] = 1'b1;
    addrs[2] = 64'h1_0000_0000; errs[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr0 = wr_cnt; rd0 = rd_cnt;
      c_req_valid = 1; c_req_we = 0; c_req_addr = addrs[i];
      #1;
      cycle();
      c_req_valid = 0;
      if (!errs[i]) cycle();
      n_tests++;
      if ({c_rsp_valid, c_rsp_err, c_rsp_rdata} !==
          {1'b1, errs[i], errs[i] ? 64'd0 : 64'h3F3E3D3C3B3A3938}) begin
        n_fail++;
        $display("FAIL range_rsp[%h]: got cv=%b ce=%b cd=%h expected 1 %b %h", addrs[i],
                 c_rsp_valid, c_rsp_err, c_rsp_rdata, errs[i],
                 errs[i] ? 64'd0 : 64'h3F3E3D3C3B3A3938);
      end
      cycle();
      n_tests++;
      if ({wr_cnt - wr0, rd_cnt - rd0} !== {32'd0, errs[i] ? 32'd0 : 32'd1}) begin
        n_fail++;
        $display("FAIL range_strobes[%h]: got wr=%0d rd=%0d expected 0 %0d", addrs[i],
                 wr_cnt - wr0, rd_cnt - rd0, errs[i] ? 0 : 1);
      end
    end
  endtask

  task automatic test_store_word();
    int wr0;
    wr0 = wr_cnt;
    c_req_valid = 1; c_req_we = 1; c_req_addr = 64'd0; c_req_wdata = 64'hDEADBEEF00000001;
    #1;
    cycle();
    c_req_valid = 0;
    n_tests++;
    if (mem_word(0) !== 64'h0706050403020100) begin
      n_fail++;
      $display("FAIL store_before_negedge: got %h expected 0706050403020100", mem_word(0));
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (mem_word(0) !== 64'hDEADBEEF00000001) begin
      n_fail++;
      $display("FAIL store_word0: got %h expected deadbeef00000001", mem_word(0));
    end
    cycle();
    n_tests++;
    if ({c_rsp_valid, c_rsp_err, c_rsp_rdata, mem_write} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL store_rsp: got cv=%b ce=%b cd=%h wr=%b expected 1 0 0 0",
               c_rsp_valid, c_rsp_err, c_rsp_rdata, mem_write);
    end
    cycle();
    n_tests++;
    if (wr_cnt - wr0 !== 1) begin
      n_fail++;
      $display("FAIL store_write_cycles: got %0d expected 1", wr_cnt - wr0);
    end
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    c_req_valid = 1; c_req_we = 1; c_req_addr = 64'd16; c_req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    cycle();
    c_req_valid = 0;
    n_tests++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_write: got %b expected 1", mem_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_write, mem_read, mem_addr, write_data} !== '0) begin
      n_fail++;
      $display("FAIL midrst_strobe_drop: got wr=%b addr=%h wd=%h expected 0 0 0", mem_write, mem_addr, write_data);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    n_tests++;
    if (mem_word(16) !== 64'h1716151413121110) begin
      n_fail++;
      $display("FAIL midrst_mem_unchanged: got %h expected 1716151413121110", mem_word(16));
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (c_rsp_valid || l_rsp_valid || c_req_ready || l_req_ready) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got activity=%b expected 0", seen);
    end
    c_req_valid = 1; c_req_we = 0; c_req_addr = 64'd16;
    #1;
    n_tests++;
    if (c_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready_after_valid: got %b expected 1", c_req_ready);
    end
    cycle();
    c_req_valid = 0;
    cycle();
    n_tests++;
    if ({c_rsp_valid, c_rsp_err, c_rsp_rdata} !== {1'b1, 1'b0, 64'h1716151413121110}) begin
      n_fail++;
      $display("FAIL midrst_readback: got cv=%b ce=%b cd=%h expected 1 0 1716151413121110",
               c_rsp_valid, c_rsp_err, c_rsp_rdata);
    end
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_round_robin();
    test_store_load();
    test_misaligned();
    test_range();
    test_store_word();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
